// File: rtl/note_scroller_pkg.sv
// note_scroller_pkg: shared video/lane constants, scan FSM encodings,
// the note slot record and the lane-to-x helper.
package note_scroller_pkg;

  // Video and lane geometry shared with the blitter and sync generator.
  localparam int SLOTS_DEF         = 8;
  localparam int SPEED_DEF         = 2;
  localparam int NOTE_HEIGHT_DEF   = 64;
  localparam int LANE_WIDTH_DEF    = 72;
  localparam int X_BASE_DEF        = 64;
  localparam int SCREEN_HEIGHT_DEF = 768;
  localparam int SCAN_START_DEF    = 1032;

  localparam int LANE_W = 3;
  localparam int HC_W   = 11;
  localparam int VC_W   = 10;
  localparam int CNT_W  = 5;

  // Scan FSM encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [VC_W-1:0]   y;
  } slot_t;

  function automatic logic [HC_W-1:0] lane_x(
    input logic [LANE_W-1:0] lane,
    input int                base,
    input int                pitch
  );
    return HC_W'(base) + HC_W'(lane) * HC_W'(pitch);
  endfunction

endpackage

// File: rtl/note_scroller_if.sv
// note_scroller_if: new-note request handshake (valid/ready + lane).
// master = note event source, slave = note_scroller.
interface note_scroller_if;
  import note_scroller_pkg::*;

  logic              note_valid;
  logic [LANE_W-1:0] note_lane;
  logic              note_ready;

  modport master (
    output note_valid,
    output note_lane,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_lane,
    output note_ready
  );

endinterface

// File: rtl/note_scroller_slot_alloc.sv
// note_slot_alloc: priority encoder over the slot valid vector.
// Ports: valid (in), free_idx = lowest free slot (out), any_free (out).
module note_slot_alloc #(
  parameter int SLOTS = 8
) (
  input  logic [SLOTS-1:0]         valid,
  output logic [$clog2(SLOTS)-1:0] free_idx,
  output logic                     any_free
);

  localparam int IW = $clog2(SLOTS);

  // Walk downward so the lowest free index wins.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_idx = IW'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_scroller.sv
// note_scroller: holds falling notes, advances them per frame and picks
// the note for each next scanline. Ports: pixel_clk, reset (sync, high),
// vsync, hcount, vcount, note (slave handshake), blob_x/blob_y/blob_en,
// active_count. Optional NOTE_SCROLLER_PAUSE_EN adds input pause.
module note_scroller
  import note_scroller_pkg::*;
#(
  parameter int SLOTS         = SLOTS_DEF,
  parameter int SPEED         = SPEED_DEF,
  parameter int NOTE_HEIGHT   = NOTE_HEIGHT_DEF,
  parameter int LANE_WIDTH    = LANE_WIDTH_DEF,
  parameter int X_BASE        = X_BASE_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int SCAN_START    = SCAN_START_DEF
) (
  input  logic             pixel_clk,
  input  logic             reset,
`ifdef NOTE_SCROLLER_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             vsync,
  input  logic [HC_W-1:0]  hcount,
  input  logic [VC_W-1:0]  vcount,
  note_scroller_if.slave   note,
  output logic [HC_W-1:0]  blob_x,
  output logic [VC_W-1:0]  blob_y,
  output logic             blob_en,
  output logic [CNT_W-1:0] active_count
);

  localparam int IW = $clog2(SLOTS);

  logic [SLOTS-1:0] valid;
  slot_t            slot  [SLOTS];
  logic [HC_W-1:0]  nxt_y [SLOTS];

  logic [IW-1:0]    free_idx;
  logic             any_free;
  logic             ins;

  logic             vsync_q;
  logic             tick;
  logic             adv;

  logic [CNT_W-1:0] cnt_d;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [HC_W-1:0]  nx;
  logic [VC_W-1:0]  ny;
  logic             nen;

  logic [HC_W-1:0]  target;
  slot_t            cur;
  logic [HC_W-1:0]  cur_y;
  logic             hit;

  note_slot_alloc #(
    .SLOTS (SLOTS)
  ) u_alloc (
    .valid    (valid),
    .free_idx (free_idx),
    .any_free (any_free)
  );

  assign note.note_ready = any_free;
  assign ins = note.note_valid & any_free;

  // Frame tick on the falling edge of the active-low vsync.
  always_ff @(posedge pixel_clk) begin
    if (reset) vsync_q <= 1'b0;
    else       vsync_q <= vsync;
  end

  assign tick = vsync_q & ~vsync;

`ifdef NOTE_SCROLLER_PAUSE_EN
  assign adv = tick & ~pause;
`else
  assign adv = tick;
`endif

  // 11-bit sums so a note near the bottom cannot wrap before retiring.
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      nxt_y[i] = {1'b0, slot[i].y} + HC_W'(SPEED);
    end
  end

  // A slot freed by a tick is still marked valid this cycle, so the
  // allocator cannot hand it out until the next one.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < SLOTS; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (adv && valid[i]) begin
          if (nxt_y[i] >= HC_W'(SCREEN_HEIGHT)) valid[i] <= 1'b0;
          else slot[i].y <= nxt_y[i][VC_W-1:0];
        end
        if (ins && (free_idx == IW'(i))) begin
          valid[i] <= 1'b1;
          slot[i]  <= '{note.note_lane, {VC_W{1'b0}}};
        end
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < SLOTS; i++) begin
      cnt_d = cnt_d + CNT_W'(valid[i]);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) active_count <= '0;
    else       active_count <= cnt_d;
  end

  // The scan looks ahead one line; line 1023 wraps to 0.
  assign target = (vcount == {VC_W{1'b1}}) ? '0
                                           : {1'b0, vcount} + 11'd1;

  always_comb begin
    cur   = slot[idx];
    cur_y = {1'b0, cur.y};
    hit   = valid[idx] && (cur_y <= target)
         && (target < cur_y + HC_W'(NOTE_HEIGHT));
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      nx      <= '0;
      ny      <= '0;
      nen     <= 1'b0;
      blob_x  <= '0;
      blob_y  <= '0;
      blob_en <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (hcount == HC_W'(SCAN_START)) begin
            state <= ST_SCAN;
            idx   <= '0;
            nen   <= 1'b0;
          end
        end
        ST_SCAN: begin
          // nen doubles as "already found": lowest index wins.
          if (hit && !nen) begin
            nx  <= lane_x(cur.lane, X_BASE, LANE_WIDTH);
            ny  <= cur.y;
            nen <= 1'b1;
          end
          if (idx == IW'(SLOTS - 1)) state <= ST_DONE;
          else idx <= idx + IW'(1);
        end
        ST_DONE: begin
          if (hcount == '0) begin
            state   <= ST_IDLE;
            blob_x  <= nx;
            blob_y  <= ny;
            blob_en <= nen;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
